// File: rtl/mkio_receiver.sv
// mkio_receiver: Manchester word receiver for an MKIO / MIL-STD-1553-style link.
// Frames a 40-half-bit word (6 sync, 32 data, 2 parity), recovers the
// command/data flag from the sync polarity, checks line validity, Manchester
// coding and odd parity, and emits one rdy_rcv or err_rcv pulse per word.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   DI1, DI0  line pair (positive / negative leg), asynchronous to clk
//   data_rcv  last good 16-bit word, loaded with rdy_rcv
//   cd_rcv    1 = command/status sync, 0 = data sync, loaded with rdy_rcv
//   rdy_rcv   one-cycle pulse: good word on data_rcv/cd_rcv
//   err_rcv   one-cycle pulse: word rejected
//   err_code  0 sync, 1 Manchester, 2 parity, 3 line invalid; loaded with err_rcv
//   busy_rcv  high from word start until the FSM is back in IDLE
module mkio_receiver #(
    parameter int unsigned HALF_BIT_CLKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DI1,
    input  logic        DI0,
    output logic [15:0] data_rcv,
    output logic        cd_rcv,
    output logic        rdy_rcv,
    output logic        err_rcv,
    output logic [1:0]  err_code,
    output logic        busy_rcv
);

    localparam int unsigned CNT_W  = $clog2(HALF_BIT_CLKS);
    localparam int unsigned IDLE_W = $clog2(2 * HALF_BIT_CLKS);
    localparam int unsigned H_W    = 6;

    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(HALF_BIT_CLKS / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HALF_BIT_CLKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(2 * HALF_BIT_CLKS - 1);

    localparam logic [1:0] ERR_SYNC = 2'd0;
    localparam logic [1:0] ERR_MAN  = 2'd1;
    localparam logic [1:0] ERR_PAR  = 2'd2;
    localparam logic [1:0] ERR_LINE = 2'd3;

    // Half-bit clock count must be even (mid-sample point) and at least 4.
    if ((HALF_BIT_CLKS < 4) || ((HALF_BIT_CLKS % 2) != 0)) begin : g_param_check
        $error("mkio_receiver: HALF_BIT_CLKS must be even and >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RX      = 2'd1,
        ST_TAIL    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Synchronizer stages
    logic d1_meta, d0_meta;
    logic s1, s0;

    // FSM and datapath registers
    state_t            state,     state_n;
    logic [CNT_W-1:0]  cnt,       cnt_n;
    logic [H_W-1:0]    hb,        hb_n;
    logic [IDLE_W-1:0] idle_cnt,  idle_cnt_n;
    logic              first,     first_n;
    logic              prev_lvl,  prev_lvl_n;
    logic [15:0]       shift,     shift_n;

    // Next values of the registered outputs
    logic [15:0] data_rcv_n;
    logic        cd_rcv_n;
    logic        rdy_rcv_n;
    logic        err_rcv_n;
    logic [1:0]  err_code_n;
    logic        busy_rcv_n;

    // Combinational helpers
    logic       line_active;
    logic       line_idle;
    logic       sample;
    logic       fail;
    logic [1:0] fail_code;

    // Two-flop synchronizer per line leg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_meta <= 1'b0;
            d0_meta <= 1'b0;
            s1      <= 1'b0;
            s0      <= 1'b0;
        end else begin
            d1_meta <= DI1;
            d0_meta <= DI0;
            s1      <= d1_meta;
            s0      <= d0_meta;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hb       <= '0;
            idle_cnt <= '0;
            first    <= 1'b0;
            prev_lvl <= 1'b0;
            shift    <= '0;
            data_rcv <= '0;
            cd_rcv   <= 1'b0;
            rdy_rcv  <= 1'b0;
            err_rcv  <= 1'b0;
            err_code <= '0;
            busy_rcv <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hb       <= hb_n;
            idle_cnt <= idle_cnt_n;
            first    <= first_n;
            prev_lvl <= prev_lvl_n;
            shift    <= shift_n;
            data_rcv <= data_rcv_n;
            cd_rcv   <= cd_rcv_n;
            rdy_rcv  <= rdy_rcv_n;
            err_rcv  <= err_rcv_n;
            err_code <= err_code_n;
            busy_rcv <= busy_rcv_n;
        end
    end

    assign line_active = s1 ^ s0;
    assign line_idle   = ~s1 & ~s0;
    assign sample      = (cnt == CNT_MID);

    // Next-state and output logic
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hb_n       = hb;
        idle_cnt_n = idle_cnt;
        first_n    = first;
        prev_lvl_n = prev_lvl;
        shift_n    = shift;
        data_rcv_n = data_rcv;
        cd_rcv_n   = cd_rcv;
        rdy_rcv_n  = 1'b0;
        err_rcv_n  = 1'b0;
        err_code_n = err_code;
        busy_rcv_n = busy_rcv;
        fail       = 1'b0;
        fail_code  = ERR_LINE;

        unique case (state)
            ST_IDLE: begin
                // The first active cycle is cnt=0 of half-bit 0.
                if (line_active) begin
                    state_n    = ST_RX;
                    cnt_n      = CNT_W'(1);
                    hb_n       = '0;
                    first_n    = s1;
                    busy_rcv_n = 1'b1;
                end
            end

            ST_RX: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    hb_n  = hb + H_W'(1);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end

                if (sample) begin
                    if (!line_active) begin
                        fail      = 1'b1;
                        fail_code = ERR_LINE;
                    end else if (hb < H_W'(3)) begin
                        if (s1 != first) begin
                            fail      = 1'b1;
                            fail_code = ERR_SYNC;
                        end
                    end else if (hb < H_W'(6)) begin
                        if (s1 == first) begin
                            fail      = 1'b1;
                            fail_code = ERR_SYNC;
                        end
                    end else if (hb < H_W'(38)) begin
                        // Even half-bit carries the data level, odd one its complement.
                        if (!hb[0]) begin
                            shift_n    = {shift[14:0], s1};
                            prev_lvl_n = s1;
                        end else if (s1 == prev_lvl) begin
                            fail      = 1'b1;
                            fail_code = ERR_MAN;
                        end
                    end else if (hb == H_W'(38)) begin
                        prev_lvl_n = s1;
                    end else begin
                        // Half-bit 39: prev_lvl holds the parity bit.
                        if (s1 == prev_lvl) begin
                            fail      = 1'b1;
                            fail_code = ERR_MAN;
                        end else if (!(^{shift, prev_lvl})) begin
                            fail      = 1'b1;
                            fail_code = ERR_PAR;
                        end else begin
                            data_rcv_n = shift;
                            cd_rcv_n   = ~first;
                            rdy_rcv_n  = 1'b1;
                            state_n    = ST_TAIL;
                        end
                    end
                end

                if (fail) begin
                    err_rcv_n  = 1'b1;
                    err_code_n = fail_code;
                    idle_cnt_n = '0;
                    state_n    = ST_RECOVER;
                end
            end

            ST_TAIL: begin
                // Let the last half-bit run out before accepting a new word.
                if (cnt == CNT_LAST) begin
                    cnt_n      = '0;
                    state_n    = ST_IDLE;
                    busy_rcv_n = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            ST_RECOVER: begin
                // Require a run of idle cycles so the rest of a bad word is ignored.
                if (line_idle) begin
                    if (idle_cnt == IDLE_LAST) begin
                        idle_cnt_n = '0;
                        state_n    = ST_IDLE;
                        busy_rcv_n = 1'b0;
                    end else begin
                        idle_cnt_n = idle_cnt + IDLE_W'(1);
                    end
                end else begin
                    idle_cnt_n = '0;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mkio_receiver.sv
// tb_mkio_receiver: directed self-checking bench for mkio_receiver.
// Drives Manchester words onto DI1/DI0 with the transmitter's timing: the line
// changes one cycle after the transmitter's imp_send edge, so a word whose
// first half-bit is driven after edge P0 has imp_send at P0-1 and E0 at P0+3.
module tb_mkio_receiver;

    localparam int unsigned HB = 8;

    logic        clk;
    logic        reset;
    logic        DI1;
    logic        DI0;
    logic [15:0] data_rcv;
    logic        cd_rcv;
    logic        rdy_rcv;
    logic        err_rcv;
    logic [1:0]  err_code;
    logic        busy_rcv;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Pulse monitor state
    int          rdy_seen = 0;
    int          err_seen = 0;
    int          rdy_cyc  = 0;
    int          err_cyc  = 0;
    logic [1:0]  err_code_seen = '0;
    logic [16:0] rdy_log[$];

    mkio_receiver #(.HALF_BIT_CLKS(HB)) dut (
        .clk      (clk),
        .reset    (reset),
        .DI1      (DI1),
        .DI0      (DI0),
        .data_rcv (data_rcv),
        .cd_rcv   (cd_rcv),
        .rdy_rcv  (rdy_rcv),
        .err_rcv  (err_rcv),
        .err_code (err_code),
        .busy_rcv (busy_rcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rdy_rcv) begin
            rdy_seen = rdy_seen + 1;
            rdy_cyc  = cyc;
            rdy_log.push_back({cd_rcv, data_rcv});
        end
        if (err_rcv) begin
            err_seen      = err_seen + 1;
            err_cyc       = cyc;
            err_code_seen = err_code;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Half-bit h of the word is w[39-h].
    function automatic logic [39:0] mk_word(input logic cd, input logic [15:0] d);
        logic [39:0] w;
        logic        f;
        logic        p;
        f = ~cd;
        w[39:34] = {f, f, f, ~f, ~f, ~f};
        for (int k = 15; k >= 0; k--) begin
            w[33 - 2 * (15 - k)] = d[k];
            w[32 - 2 * (15 - k)] = ~d[k];
        end
        p = ~(^d);
        w[1] = p;
        w[0] = ~p;
        return w;
    endfunction

    // Drive one 40-half-bit word; from kill_from on the line is 0/0,
    // and reset is raised at the start of half-bit rst_at (left high).
    task automatic send_word(input logic [39:0] w, input int kill_from,
                             input int rst_at, output int t0);
        t0 = 0;
        for (int h = 0; h < 40; h++) begin
            @(posedge clk);
            #1;
            if (h == 0) t0 = cyc;
            if (h == rst_at) reset = 1'b1;
            if (h >= kill_from) begin
                DI1 = 1'b0;
                DI0 = 1'b0;
            end else begin
                DI1 = w[39 - h];
                DI0 = ~w[39 - h];
            end
            repeat (HB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1;
        DI1 = 1'b0;
        DI0 = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          t0;
    int          t1;
    int          r0;
    int          e0;
    int          q;
    int          busy_low_cyc;
    logic [39:0] w;

    initial begin
        reset = 1'b1;
        DI1   = 1'b0;
        DI0   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy",  32'(rdy_rcv),  32'd0);
        check("rst_err",  32'(err_rcv),  32'd0);
        check("rst_data", 32'(data_rcv), 32'd0);
        check("rst_cd",   32'(cd_rcv),   32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_busy", 32'(busy_rcv), 32'd0);
        reset = 1'b0;
        idle_cycles(5);

        // Good command word, latency from imp_send (P0-1) must be 320
        r0 = rdy_seen; e0 = err_seen;
        send_word(mk_word(1'b1, 16'hA55A), 40, 40, t0);
        idle_cycles(20);
        check("a55a_rdy_n",   32'(rdy_seen - r0),   32'd1);
        check("a55a_err_n",   32'(err_seen - e0),   32'd0);
        check("a55a_latency", 32'(rdy_cyc - t0 + 1), 32'd320);
        check("a55a_data",    32'(data_rcv),        32'h0000A55A);
        check("a55a_cd",      32'(cd_rcv),          32'd1);
        check("a55a_busy",    32'(busy_rcv),        32'd0);

        // Back-to-back data words with a single idle cycle between them
        r0 = rdy_seen; e0 = err_seen;
        rdy_log.delete();
        send_word(mk_word(1'b0, 16'h0000), 40, 40, t0);
        send_word(mk_word(1'b0, 16'hFFFF), 40, 40, t1);
        idle_cycles(20);
        check("b2b_rdy_n",  32'(rdy_seen - r0), 32'd2);
        check("b2b_err_n",  32'(err_seen - e0), 32'd0);
        check("b2b_gap",    32'(t1 - t0),       32'd321);
        if (rdy_log.size() == 2) begin
            check("b2b_word0", 32'(rdy_log[0]), 32'h00000);
            check("b2b_word1", 32'(rdy_log[1]), 32'h0FFFF);
        end else begin
            check("b2b_log_size", 32'(rdy_log.size()), 32'd2);
        end
        check("b2b_latency2", 32'(rdy_cyc - t1 + 1), 32'd320);

        // Parity pair inverted: parity error, data_rcv keeps 16'hFFFF
        r0 = rdy_seen; e0 = err_seen;
        w = mk_word(1'b1, 16'h1234);
        w[1] = ~w[1];
        w[0] = ~w[0];
        send_word(w, 40, 40, t0);
        idle_cycles(40);
        check("par_err_n",    32'(err_seen - e0),   32'd1);
        check("par_rdy_n",    32'(rdy_seen - r0),   32'd0);
        check("par_code",     32'(err_code_seen),   32'd2);
        check("par_code_out", 32'(err_code),        32'd2);
        check("par_err_cyc",  32'(err_cyc - t0),    32'd319);
        check("par_data",     32'(data_rcv),        32'h0000FFFF);
        check("par_cd",       32'(cd_rcv),          32'd0);
        r0 = rdy_seen;
        send_word(mk_word(1'b1, 16'h1234), 40, 40, t0);
        idle_cycles(20);
        check("par_next_rdy",  32'(rdy_seen - r0), 32'd1);
        check("par_next_data", 32'(data_rcv),      32'h00001234);
        check("par_next_cd",   32'(cd_rcv),        32'd1);

        // Data bit 15 sent as 1/1: Manchester error at E0+60
        r0 = rdy_seen; e0 = err_seen;
        w = mk_word(1'b1, 16'h1234);
        w[33] = 1'b1;
        w[32] = 1'b1;
        send_word(w, 40, 40, t0);
        busy_low_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_rcv) begin
                busy_low_cyc = cyc;
                break;
            end
        end
        check("man_err_n",   32'(err_seen - e0),       32'd1);
        check("man_rdy_n",   32'(rdy_seen - r0),       32'd0);
        check("man_code",    32'(err_code_seen),       32'd1);
        check("man_err_cyc", 32'(err_cyc - t0),        32'd63);
        check("man_busy_lo", 32'(busy_low_cyc - t0),  32'd338);
        idle_cycles(10);

        // Line dropped to 0/0 from half-bit 20
        e0 = err_seen;
        send_word(mk_word(1'b0, 16'h5A5A), 20, 40, t0);
        idle_cycles(40);
        check("line_err_n",   32'(err_seen - e0), 32'd1);
        check("line_code",    32'(err_code_seen), 32'd3);
        check("line_err_cyc", 32'(err_cyc - t0),  32'd167);
        check("line_busy",    32'(busy_rcv),      32'd0);

        // Sync 001111: half-bit 2 does not match the first level
        e0 = err_seen;
        w = mk_word(1'b1, 16'h00FF);
        w[39:34] = 6'b001111;
        send_word(w, 40, 40, t0);
        idle_cycles(40);
        check("sync_err_n",   32'(err_seen - e0), 32'd1);
        check("sync_code",    32'(err_code_seen), 32'd0);
        check("sync_err_cyc", 32'(err_cyc - t0),  32'd23);

        // One-cycle glitch in IDLE: line error at the h0 sample
        e0 = err_seen; r0 = rdy_seen;
        @(posedge clk);
        #1;
        q   = cyc;
        DI1 = 1'b1;
        @(posedge clk);
        #1;
        DI1 = 1'b0;
        idle_cycles(40);
        check("glitch_err_n",   32'(err_seen - e0), 32'd1);
        check("glitch_rdy_n",   32'(rdy_seen - r0), 32'd0);
        check("glitch_code",    32'(err_code_seen), 32'd3);
        check("glitch_err_cyc", 32'(err_cyc - q),   32'd7);
        check("glitch_busy",    32'(busy_rcv),      32'd0);

        // Reset at half-bit 25 of a good word: no pulse, outputs cleared
        r0 = rdy_seen; e0 = err_seen;
        send_word(mk_word(1'b1, 16'hC3C3), 40, 25, t0);
        #1;
        check("rst_mid_rdy_n", 32'(rdy_seen - r0), 32'd0);
        check("rst_mid_err_n", 32'(err_seen - e0), 32'd0);
        check("rst_mid_data",  32'(data_rcv),      32'd0);
        check("rst_mid_cd",    32'(cd_rcv),        32'd0);
        check("rst_mid_code",  32'(err_code),      32'd0);
        check("rst_mid_busy",  32'(busy_rcv),      32'd0);
        reset = 1'b0;
        idle_cycles(5);
        send_word(mk_word(1'b0, 16'hBEEF), 40, 40, t0);
        idle_cycles(20);
        check("post_rst_rdy_n", 32'(rdy_seen - r0), 32'd1);
        check("post_rst_err_n", 32'(err_seen - e0), 32'd0);
        check("post_rst_data",  32'(data_rcv),      32'h0000BEEF);
        check("post_rst_cd",    32'(cd_rcv),        32'd0);
        check("post_rst_lat",   32'(rdy_cyc - t0 + 1), 32'd320);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mkio_receiver.md
Name: mkio_receiver

Overview:
- MKIO (MIL-STD-1553-style) Manchester word receiver; consumes the DI1/DI0 line pair driven by the link's transmit stage and delivers decoded 16-bit words.
- Frames a 40-half-bit word: 6 half-bit sync, 32 Manchester data half-bits sent MSB first, 2 parity half-bits.
- Recovers the command/data flag from sync polarity, checks odd parity and Manchester/line validity, and reports one ready or error pulse per word.

Parameters:
HALF_BIT_CLKS, 8, clocks per Manchester half-bit; must be even and at least 4. Counter widths are derived from it.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
DI1  input  1  line, positive leg; asynchronous to clk
DI0  input  1  line, negative leg; asynchronous to clk
data_rcv  output  16  last good word; updated only with rdy_rcv
cd_rcv  output  1  1 = command/status sync, 0 = data sync; updated only with rdy_rcv
rdy_rcv  output  1  one-cycle pulse: good word on data_rcv/cd_rcv
err_rcv  output  1  one-cycle pulse: word rejected
err_code  output  2  0 sync, 1 Manchester, 2 parity, 3 line invalid; valid with err_rcv, held until next err_rcv
busy_rcv  output  1  high from word start until return to IDLE

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-high. All outputs are 0, FSM is in IDLE, and synchronizers are cleared. Reset mid-word discards the word and produces no pulse.
- Synchronizer: DI1 and DI0 each pass through 2 flops. All logic uses the synchronized pair s1/s0.
- Line states: active = s1 != s0; idle = both 0; invalid = both equal.
- Line level: the level of a half-bit is s1.

FSM states:
- IDLE: on the first active cycle, go to RX at edge E0. That cycle counts as cnt=0, h=0. Latch first = s1. busy_rcv=1.
- RX: cnt runs 0..HALF_BIT_CLKS-1, then wraps and increments h (0..39). Sample at cnt == HALF_BIT_CLKS/2:
  - Any sample with s1 == s0: error code 3.
  - h0-2 must equal first; h3-5 must equal ~first. Otherwise error code 0.
  - cd = ~first (cd=1 sync is 000111, cd=0 sync is 111000).
  - Data bit k (15 down to 0) is the level at h = 6 + 2*(15-k). The level at the next half-bit must be its complement, else error code 1.
  - Parity bit p is the level at h38; h39 must equal ~p, else error code 1.
  - Odd parity required: XOR(data, p) = 1, else error code 2.
- Good completion, at the h39 sample edge:
  - data_rcv and cd_rcv load; rdy_rcv=1 for one cycle.
  - Go to TAIL.
- Error, at the first failing sample:
  - err_rcv=1 for one cycle and err_code loads. Remaining checks are skipped.
  - Go to RECOVER. data_rcv/cd_rcv unchanged.
- TAIL: finish the remaining cnt of h39, then go to IDLE with busy_rcv=0.
- RECOVER: wait for 2*HALF_BIT_CLKS consecutive idle cycles (any active cycle restarts the count), then go to IDLE with busy_rcv=0.
- Latency: rdy_rcv asserts at edge E0 + 39*HALF_BIT_CLKS + HALF_BIT_CLKS/2 (E0+316 at default). In direct loopback from the transmit stage, E0 = imp_send edge + 4, so rdy_rcv is at imp_send edge + 320.
- Back-to-back: after TAIL the FSM is in IDLE at E0+320. The next word's first active cycle is accepted from then on; a gap of at least 1 idle cycle is guaranteed by the transmitter.
- Truncated word: the line going 0/0 mid-word is caught at the next sample as code 3.
- Glitch in IDLE: a 1-cycle active pulse starts RX, fails at h0 with code 3, then RECOVER.
- Pulses never overlap: at most one of rdy_rcv/err_rcv per word.

Test Plan:
- Loopback, transmitter sends cd=1, data 16'hA55A -> rdy_rcv at imp_send edge + 320; data_rcv=16'hA55A, cd_rcv=1, err_rcv never high.
- Loopback cd=0, data 16'h0000, then immediately 16'hFFFF (imp_send on the first cycle busy_send is low) -> two rdy pulses, 16'h0000/cd 0 then 16'hFFFF/cd 0.
- Driven word 16'h1234 with the parity half-bit pair inverted -> err_rcv, err_code=2, data_rcv keeps its previous value; rdy_rcv after the next good word.
- Data bit 15 sent as a 11 pair (no mid-bit transition) -> err_rcv at the h7 sample edge (E0+60), err_code=1. No rdy. busy_rcv low only after 16 idle cycles.
- Line forced 0/0 from h20 onward -> err_code=3 at the h20 sample edge. Sync 0011 11 (bad h2) -> err_code=0.
- Assert reset at h25 of a good word -> no pulse; outputs 0. The following clean word is received correctly.
